// File: rtl/ledstripe_pkg.sv
// ledstripe_pkg: types and constants shared by the LED-stripe datapath.
//   BITS_PER_LED         - bits per GRB pixel
//   DEFAULT_RESET_CYCLES - default latch-gap length in clk cycles
//   pixel_t              - one 24-bit GRB pixel
//   state_t              - pixel_serializer frame state
package ledstripe_pkg;

  localparam int BITS_PER_LED         = 24;
  localparam int DEFAULT_RESET_CYCLES = 3000;

  typedef logic [BITS_PER_LED-1:0] pixel_t;

  typedef enum logic {
    RST_WAIT,
    SHIFT
  } state_t;

endpackage

// File: rtl/gap_timer.sv
// gap_timer: counts a fixed latch gap of RESET_CYCLES clk cycles.
//   clk   - system clock
//   rstn  - synchronous active-low reset; a reset begins a full gap
//   start - restart the gap; count reads 0 in the following cycle
//   count - cycles elapsed in the current gap (0 .. RESET_CYCLES-1)
//   done  - high in the last cycle of the gap (count == RESET_CYCLES-1)
module gap_timer #(
  parameter  int RESET_CYCLES = 3000,
  localparam int CNT_W        = $clog2(RESET_CYCLES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic             r_running;
  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == CNT_W'(RESET_CYCLES - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_running <= 1'b1;
      r_count   <= '0;
    end else if (start) begin
      r_running <= 1'b1;
      r_count   <= '0;
    end else if (r_running) begin
      if (w_last) begin
        r_running <= 1'b0;
        r_count   <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;
  assign done  = r_running & w_last;

endmodule

// File: rtl/pixel_serializer.sv
// pixel_serializer: fetches GRB pixels from the frame buffer and presents
// them MSB first, one bit per new_bit_rqst, to the LED bit-timing generator.
// Between frames it times the stripe latch gap itself.
//   clk              - system clock
//   rstn             - synchronous active-low reset
//   pix_rd_en        - frame-buffer read strobe
//   pix_addr         - frame-buffer read address (held while not reading)
//   pix_data         - read data, valid the cycle after pix_rd_en
//   new_bit_rqst     - one-cycle request from the timing generator
//   bit_to_transmit  - current bit, sampled by the consumer with its request
//   all_bits_shifted - combinational: request arrived with no bit available
//   reset_finish     - one-cycle pulse at the end of the latch gap
//   frame_sync       - one-cycle pulse at the start of the latch gap
module pixel_serializer
  import ledstripe_pkg::*;
#(
  parameter int NUM_LEDS     = 64,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int ADDR_W       = $clog2(NUM_LEDS)
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  input  pixel_t            pix_data,
  input  logic              new_bit_rqst,
  output logic              bit_to_transmit,
  output logic              all_bits_shifted,
  output logic              reset_finish,
  output logic              frame_sync
);

  localparam int GAP_W = $clog2(RESET_CYCLES);
  localparam int BIT_W = $clog2(BITS_PER_LED);

  state_t            r_state;
  pixel_t            r_shift;
  pixel_t            r_next_buf;
  logic              r_next_valid;
  logic              r_bit_valid;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [ADDR_W-1:0] r_led_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en;
  logic              r_data_vld;
  logic              r_reset_finish;
  logic              r_frame_sync;

  logic [GAP_W-1:0]  w_gap_count;
  logic              w_gap_done;
  logic              w_req;
  logic              w_end;
  logic              w_last_bit;
  logic              w_last_led;
  logic              w_boundary;
  logic [31:0]       w_led_plus2;

  assign w_req       = (r_state == SHIFT) & new_bit_rqst & r_bit_valid;
  assign w_end       = (r_state == SHIFT) & new_bit_rqst & ~r_bit_valid;
  assign w_last_bit  = (r_bit_cnt == BIT_W'(BITS_PER_LED - 1));
  assign w_last_led  = (r_led_cnt == ADDR_W'(NUM_LEDS - 1));
  assign w_boundary  = w_req & w_last_bit & ~w_last_led;
  // Computed at 32 bits so led_cnt+2 cannot wrap in a narrow address.
  assign w_led_plus2 = 32'(r_led_cnt) + 32'd2;

  gap_timer #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rstn  (rstn),
    .start (w_end),
    .count (w_gap_count),
    .done  (w_gap_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= RST_WAIT;
      r_shift        <= '0;
      r_next_buf     <= '0;
      r_next_valid   <= 1'b0;
      r_bit_valid    <= 1'b0;
      r_bit_cnt      <= '0;
      r_led_cnt      <= '0;
      r_addr         <= '0;
      r_rd_en        <= 1'b0;
      r_data_vld     <= 1'b0;
      r_reset_finish <= 1'b0;
      r_frame_sync   <= 1'b0;
    end else begin
      // Strobes and pulses default low; branches below raise them for one cycle.
      r_rd_en        <= 1'b0;
      r_reset_finish <= 1'b0;
      r_frame_sync   <= 1'b0;
      r_data_vld     <= r_rd_en;

      case (r_state)
        RST_WAIT: begin
          // Prefetch pixels 0 and 1 at the start of the gap. The strobe is
          // registered, so each capture lands two counts after its read.
          if (w_gap_count == GAP_W'(0)) begin
            r_rd_en <= 1'b1;
            r_addr  <= '0;
          end
          if (w_gap_count == GAP_W'(1)) begin
            r_rd_en <= 1'b1;
            r_addr  <= ADDR_W'(1);
          end
          if (w_gap_count == GAP_W'(2)) begin
            r_shift <= pix_data;
          end
          if (w_gap_count == GAP_W'(3)) begin
            r_next_buf   <= pix_data;
            r_next_valid <= 1'b1;
          end
          if (w_gap_done) begin
            r_reset_finish <= 1'b1;
            r_bit_valid    <= 1'b1;
            r_led_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_state        <= SHIFT;
          end
        end

        SHIFT: begin
          // Data for a read issued at a pixel boundary.
          if (r_data_vld) begin
            r_next_buf   <= pix_data;
            r_next_valid <= 1'b1;
          end
          if (w_req) begin
            if (!w_last_bit) begin
              r_shift   <= {r_shift[BITS_PER_LED-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (!w_last_led) begin
              r_shift      <= r_next_buf;
              r_led_cnt    <= r_led_cnt + 1'b1;
              r_bit_cnt    <= '0;
              r_next_valid <= 1'b0;
              if (w_led_plus2 < 32'(NUM_LEDS)) begin
                r_rd_en <= 1'b1;
                r_addr  <= ADDR_W'(w_led_plus2);
              end
            end else begin
              r_bit_valid <= 1'b0;
            end
          end
          if (w_end) begin
            r_frame_sync <= 1'b1;
            r_state      <= RST_WAIT;
          end
        end

        default: r_state <= RST_WAIT;
      endcase
    end
  end

  // A pixel boundary must always find the next pixel already fetched.
  a_no_underrun : assert property (
    @(posedge clk) disable iff (!rstn) w_boundary |-> r_next_valid
  );

  assign pix_rd_en        = r_rd_en;
  assign pix_addr         = r_addr;
  assign bit_to_transmit  = r_shift[BITS_PER_LED-1];
  assign reset_finish     = r_reset_finish;
  assign frame_sync       = r_frame_sync;
  assign all_bits_shifted = rstn & new_bit_rqst & ~r_bit_valid;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer: a 2-LED instance driven through the
// frame, gap and reset scenarios, plus a 4-LED instance that exercises the
// in-frame prefetch path. Both use an 8-cycle latch gap.
module tb_pixel_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        rqst, rd_en, bit_o, abs, rf, fs;
  logic        addr;
  logic [23:0] data;
  logic        rqst4, rd4, bit4, abs4, rf4, fs4;
  logic [1:0]  addr4;
  logic [23:0] data4;

  logic [23:0] mem2 [2];
  logic [23:0] mem4 [4];

  int n_pass  = 0;
  int n_total = 0;

  pixel_serializer #(.NUM_LEDS(2), .RESET_CYCLES(8)) dut (
    .clk (clk), .rstn (rstn), .pix_rd_en (rd_en), .pix_addr (addr),
    .pix_data (data), .new_bit_rqst (rqst), .bit_to_transmit (bit_o),
    .all_bits_shifted (abs), .reset_finish (rf), .frame_sync (fs)
  );

  pixel_serializer #(.NUM_LEDS(4), .RESET_CYCLES(8)) dut4 (
    .clk (clk), .rstn (rstn), .pix_rd_en (rd4), .pix_addr (addr4),
    .pix_data (data4), .new_bit_rqst (rqst4), .bit_to_transmit (bit4),
    .all_bits_shifted (abs4), .reset_finish (rf4), .frame_sync (fs4)
  );

  // Synchronous-read frame buffers.
  always @(posedge clk) if (rd_en) data  <= mem2[addr];
  always @(posedge clk) if (rd4)   data4 <= mem4[addr4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    rqst  = 1'b0;
    rqst4 = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  // One request: sample bit and end-of-frame flag in the request cycle.
  task automatic req_bit(output logic b, output logic a);
    rqst = 1'b1;
    #1;
    b = bit_o;
    a = abs;
    @(posedge clk);
    #1;
    rqst = 1'b0;
  endtask

  task automatic shift_bits(input int n, input int sp,
                            output logic [47:0] w, output logic any_abs);
    logic b, a;
    w       = '0;
    any_abs = 1'b0;
    for (int i = 0; i < n; i++) begin
      req_bit(b, a);
      w       = {w[46:0], b};
      any_abs = any_abs | a;
      repeat (sp - 1) tick();
    end
  endtask

  // Cycles from now until reset_finish is seen; -1 on timeout.
  task automatic wait_finish(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40 && cyc < 0; i++) begin
      tick();
      if (rf === 1'b1) cyc = i;
    end
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    rqst  = 1'b1;
    rqst4 = 1'b0;
    repeat (2) tick();
    n_total++;
    if ({rd_en, addr, bit_o, rf, fs} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000", {rd_en, addr, bit_o, rf, fs});
    else n_pass++;
    n_total++;
    if (abs !== 1'b0)
      $display("FAIL reset_abs: got %b expected 0", abs);
    else n_pass++;
    rqst = 1'b0;
  endtask

  task automatic test_frame();
    int cyc;
    logic [47:0] w;
    logic any_abs, b, a;
    do_reset();
    wait_finish(cyc);
    n_total++;
    if (cyc !== 8) $display("FAIL frame_finish_cycle: got %0d expected 8", cyc);
    else n_pass++;
    shift_bits(48, 6, w, any_abs);
    n_total++;
    if (w !== 48'hA50F3C800001) $display("FAIL frame_bits: got %h expected a50f3c800001", w);
    else n_pass++;
    n_total++;
    if (any_abs !== 1'b0) $display("FAIL frame_early_abs: got %b expected 0", any_abs);
    else n_pass++;
    req_bit(b, a);
    n_total++;
    if (a !== 1'b1) $display("FAIL frame_end_abs: got %b expected 1", a);
    else n_pass++;
    n_total++;
    if (fs !== 1'b1) $display("FAIL frame_sync_pulse: got %b expected 1", fs);
    else n_pass++;
    tick();
    n_total++;
    if (fs !== 1'b0) $display("FAIL frame_sync_width: got %b expected 0", fs);
    else n_pass++;
  endtask

  task automatic test_idle_gap();
    int pulses, first;
    do_reset();
    tick();
    n_total++;
    if ({rd_en, addr} !== 2'b10) $display("FAIL gap_read0: got %b expected 10", {rd_en, addr});
    else n_pass++;
    tick();
    n_total++;
    if ({rd_en, addr} !== 2'b11) $display("FAIL gap_read1: got %b expected 11", {rd_en, addr});
    else n_pass++;
    tick();
    n_total++;
    if ({rd_en, addr} !== 2'b01) $display("FAIL gap_addr_hold: got %b expected 01", {rd_en, addr});
    else n_pass++;
    pulses = 0;
    first  = -1;
    for (int i = 4; i <= 30; i++) begin
      tick();
      if (rf === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    n_total++;
    if (first !== 8 || pulses !== 1)
      $display("FAIL gap_finish_pulse: got cycle %0d count %0d expected cycle 8 count 1", first, pulses);
    else n_pass++;
    n_total++;
    if (bit_o !== 1'b1) $display("FAIL gap_first_bit: got %b expected 1", bit_o);
    else n_pass++;
  endtask

  task automatic test_rqst_in_gap();
    int cyc;
    logic [47:0] w;
    logic any_abs, b, a;
    do_reset();
    repeat (3) tick();
    req_bit(b, a);
    n_total++;
    if (a !== 1'b1) $display("FAIL gap_rqst_abs: got %b expected 1", a);
    else n_pass++;
    wait_finish(cyc);
    n_total++;
    if (cyc !== 4) $display("FAIL gap_rqst_finish: got %0d expected 4", cyc);
    else n_pass++;
    shift_bits(8, 5, w, any_abs);
    n_total++;
    if (w[7:0] !== 8'hA5 || any_abs !== 1'b0)
      $display("FAIL gap_rqst_bits: got %h abs %b expected a5 abs 0", w[7:0], any_abs);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic [47:0] w;
    logic any_abs, b, a;
    do_reset();
    wait_finish(cyc);
    shift_bits(30, 5, w, any_abs);
    n_total++;
    if (w[29:0] !== 30'h2943CF20) $display("FAIL mid_bits: got %h expected 2943cf20", w[29:0]);
    else n_pass++;
    rstn = 1'b0;
    tick();
    n_total++;
    if ({rd_en, addr, bit_o, rf, fs, abs} !== 6'b0)
      $display("FAIL mid_reset_outputs: got %b expected 000000", {rd_en, addr, bit_o, rf, fs, abs});
    else n_pass++;
    rstn = 1'b1;
    req_bit(b, a);
    n_total++;
    if (a !== 1'b1) $display("FAIL mid_first_rqst_abs: got %b expected 1", a);
    else n_pass++;
    wait_finish(cyc);
    n_total++;
    if (cyc !== 7) $display("FAIL mid_restart_gap: got %0d expected 7", cyc);
    else n_pass++;
    req_bit(b, a);
    n_total++;
    if (b !== 1'b1 || a !== 1'b0)
      $display("FAIL mid_restart_bit: got bit %b abs %b expected bit 1 abs 0", b, a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [47:0] w;
    logic any_abs, b, a;
    do_reset();
    wait_finish(cyc);
    shift_bits(48, 4, w, any_abs);
    req_bit(b, a);
    n_total++;
    if (a !== 1'b1 || fs !== 1'b1)
      $display("FAIL b2b_end1: got abs %b sync %b expected 1 1", a, fs);
    else n_pass++;
    mem2[0] = 24'hFFFFFF;
    mem2[1] = 24'h000000;
    wait_finish(cyc);
    n_total++;
    if (cyc !== 8) $display("FAIL b2b_gap: got %0d expected 8", cyc);
    else n_pass++;
    shift_bits(48, 6, w, any_abs);
    n_total++;
    if (w !== 48'hFFFFFF000000 || any_abs !== 1'b0)
      $display("FAIL b2b_frame2: got %h abs %b expected ffffff000000 abs 0", w, any_abs);
    else n_pass++;
    req_bit(b, a);
    mem2[0] = 24'hA50F3C;
    mem2[1] = 24'h800001;
    n_total++;
    if (a !== 1'b1 || fs !== 1'b1)
      $display("FAIL b2b_end2: got abs %b sync %b expected 1 1", a, fs);
    else n_pass++;
  endtask

  // Starts in the gap opened by the end of test_back_to_back.
  task automatic test_tight_spacing();
    int cyc;
    logic [47:0] w;
    logic any_abs;
    wait_finish(cyc);
    shift_bits(48, 4, w, any_abs);
    n_total++;
    if (w !== 48'hA50F3C800001 || any_abs !== 1'b0)
      $display("FAIL tight_bits: got %h abs %b expected a50f3c800001 abs 0", w, any_abs);
    else n_pass++;
  endtask

  task automatic test_four_leds();
    int cyc;
    logic [95:0] w;
    logic any_abs;
    do_reset();
    cyc = -1;
    for (int i = 1; i <= 40 && cyc < 0; i++) begin
      tick();
      if (rf4 === 1'b1) cyc = i;
    end
    n_total++;
    if (cyc !== 8) $display("FAIL four_finish: got %0d expected 8", cyc);
    else n_pass++;
    w       = '0;
    any_abs = 1'b0;
    for (int i = 0; i < 96; i++) begin
      rqst4 = 1'b1;
      #1;
      w       = {w[94:0], bit4};
      any_abs = any_abs | abs4;
      @(posedge clk);
      #1;
      rqst4 = 1'b0;
      repeat (3) tick();
    end
    n_total++;
    if (w !== 96'h12345689ABCDF0E1D20F1E2D || any_abs !== 1'b0)
      $display("FAIL four_bits: got %h abs %b expected 12345689abcdf0e1d20f1e2d abs 0", w, any_abs);
    else n_pass++;
    rqst4 = 1'b1;
    #1;
    n_total++;
    if (abs4 !== 1'b1) $display("FAIL four_end_abs: got %b expected 1", abs4);
    else n_pass++;
    @(posedge clk);
    #1;
    rqst4 = 1'b0;
    n_total++;
    if (fs4 !== 1'b1) $display("FAIL four_frame_sync: got %b expected 1", fs4);
    else n_pass++;
  endtask

  initial begin
    rstn    = 1'b0;
    rqst    = 1'b0;
    rqst4   = 1'b0;
    mem2[0] = 24'hA50F3C;
    mem2[1] = 24'h800001;
    mem4[0] = 24'h123456;
    mem4[1] = 24'h89ABCD;
    mem4[2] = 24'hF0E1D2;
    mem4[3] = 24'h0F1E2D;
    test_reset();
    test_frame();
    test_idle_gap();
    test_rqst_in_gap();
    test_mid_reset();
    test_back_to_back();
    test_tight_spacing();
    test_four_leds();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
